multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Sequencer for the multi-cycle variant of the RISC-V core. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, sharing one unified instruction/data memory port over a req/ready handshake. It drives the PC, IR, register-file and writeback-mux strobes. The per-opcode static controls (alu_src, ALU_OP) stay in the combinational control decoder; this block adds only the temporal sequencing.

Parameters:
MEM_TIMEOUT, 255, cycles mem_req may stay high without mem_ready before trapping (1..65535).
TW, 16, width of the internal wait counter; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instruction[6:0] from the IR; sampled in DECODE only
branch_taken  in  1  branch comparison result; valid in EXEC
mem_ready  in  1  memory completion; may assert in the same cycle as mem_req
mem_req  out  1  memory access request
mem_we  out  1  write enable; qualified by mem_req
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_write  out  1  load IR with the fetched word
pc_write  out  1  update PC
pc_src  out  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR ALU result with bit0 cleared
reg_write  out  1  register-file write strobe
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
instr_retired  out  1  one-cycle pulse per completed instruction
illegal_op  out  1  sticky; unknown opcode
mem_timeout  out  1  sticky; handshake timeout
state  out  3  current state, for debug

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous and active-low.
- Reset values: state = IDLE and every output is 0. Reset asserted mid-instruction aborts it immediately, with no pending strobes.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all outputs 0. Goes to FETCH on the first clock after rst_n deasserts.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready: ir_write=1 for that cycle, then DECODE.
- DECODE (one cycle):
  - Latch the opcode class into an internal register; later opcode changes are ignored.
  - Known classes: R, I-arith, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Known opcode -> EXEC.
  - Any other opcode -> TRAP with illegal_op=1.
- EXEC (one cycle):
  - BRANCH: pc_write=1, pc_src = branch_taken ? 01 : 00, instr_retired=1, then FETCH.
  - LOAD or STORE -> MEM.
  - All other classes -> WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we = STORE.
  - On mem_ready, STORE: pc_write=1, pc_src=00, instr_retired=1, then FETCH.
  - On mem_ready, LOAD -> WB.
- WB (one cycle): reg_write=1, pc_write=1, instr_retired=1, then FETCH.
  - wb_sel: LOAD -> 01; JAL/JALR -> 10; else 00.
  - pc_src: JAL -> 10; JALR -> 11; else 00.
- Latency with zero-wait memory, in cycles per instruction: branch 3; store 4; R/I/LUI/AUIPC/JAL/JALR 4; load 5. Each wait cycle on mem_ready adds 1.
- Handshake:
  - mem_req stays high continuously until the cycle in which mem_ready=1. It deasserts the following cycle unless the next state also requests.
  - mem_ready while mem_req=0 is ignored.
- Wait counter:
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0: goes to TRAP, mem_timeout=1. mem_ready in that same cycle wins; no timeout.
  - Saturates; never wraps.
- TRAP: all strobes 0, flags held. Exit only by reset.
- Strobe rules:
  - At most one pc_write and one instr_retired per instruction.
  - reg_write and mem_we are never high in the same cycle.
- Implementation: outputs are combinational from state, latched class and branch_taken, with no glitch-sensitive use.

Decomposition:
- Package ctrl_pkg holds:
  - the opcode constants shared with the control decoder;
  - the state encoding;
  - pc_src and wb_sel encodings;
  - the opcode-class enum.
- One sub-module, mem_wait_timer: counter, clear/enable inputs, timeout output, parameterised by MEM_TIMEOUT and TW.

Test Plan:
- Reset release, memory with zero wait, ADDI (0010011) -> IDLE, FETCH, DECODE, EXEC, WB. WB has reg_write=1, wb_sel=00, pc_src=00, instr_retired=1. Four cycles from FETCH to retire.
- LW (0000011), with mem_ready delayed 2 cycles in MEM -> mem_req/mem_addr_sel=1 held 3 cycles, mem_we=0. WB has wb_sel=01. Retire 7 cycles after FETCH entry.
- BEQ (1100011) with branch_taken=1, then again with 0 -> EXEC pc_src=01 then 00. reg_write never asserted. Three cycles each.
- JALR (1100111) -> WB has wb_sel=10, pc_src=11, reg_write=1. SW (0100011) -> MEM has mem_we=1 and retires from MEM.
- Opcode 1111111 in DECODE -> TRAP, illegal_op=1 sticky. No further mem_req until rst_n pulse; then returns to IDLE.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_timeout=1 and state=TRAP after 4 wait cycles. Repeat with mem_ready on the 4th cycle -> no trap. Assert rst_n low mid-MEM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, state/pc_src/wb_sel encodings and opcode classes
// for the multi-cycle control sequencer.
package ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILL
    } cls_t;

    function automatic cls_t decode_class(input logic [6:0] op);
        case (op)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_JAL:    return CLS_JAL;
            OP_JALR:   return CLS_JALR;
            OP_LUI:    return CLS_LUI;
            OP_AUIPC:  return CLS_AUIPC;
            default:   return CLS_ILL;
        endcase
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory-request cycles and flags a timeout.
// Ports: clk, rst_n (async active-low), clr (restart count), en (request
// pending without ready), timeout (combinational: this stalled cycle is the
// MEM_TIMEOUT-th one).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TW          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    logic [TW-1:0] cnt;

    // cnt counts earlier stalled cycles, so the stall that brings it to
    // MEM_TIMEOUT is the one that fires.
    assign timeout = en && (cnt >= TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != TW'(MEM_TIMEOUT))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle core.
// Inputs: clk, rst_n (async active-low), opcode (sampled in DECODE),
// branch_taken (used in EXEC), mem_ready (memory handshake completion).
// Outputs: memory request/write/address select, IR/PC/register-file strobes,
// pc_src and wb_sel muxes, retire pulse, sticky illegal_op/mem_timeout, state.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TW          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [2:0] state
);
    state_t state_q, next_state;
    cls_t   cls;
    logic   to;
    logic   entering;

    assign state = state_q;
    assign entering = (next_state != state_q) && (next_state == S_FETCH || next_state == S_MEM);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TW(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (entering || (mem_req && mem_ready)),
        .en     (mem_req && !mem_ready),
        .timeout(to)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cls         <= CLS_R;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == S_DECODE)
                cls <= decode_class(opcode);
            if (state_q == S_DECODE && next_state == S_TRAP)
                illegal_op <= 1'b1;
            if (to)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        next_state    = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        instr_retired = 1'b0;
        case (state_q)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                ir_write   = mem_ready;
                next_state = mem_ready ? S_DECODE : to ? S_TRAP : S_FETCH;
            end
            S_DECODE: next_state = (decode_class(opcode) == CLS_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (cls == CLS_BRANCH) begin
                    pc_write      = 1'b1;
                    pc_src        = branch_taken ? PC_BRANCH : PC_PLUS4;
                    instr_retired = 1'b1;
                    next_state    = S_FETCH;
                end else begin
                    next_state = (cls == CLS_LOAD || cls == CLS_STORE) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CLS_STORE);
                if (mem_ready) begin
                    pc_write      = (cls == CLS_STORE);
                    instr_retired = (cls == CLS_STORE);
                    next_state    = (cls == CLS_STORE) ? S_FETCH : S_WB;
                end else if (to) begin
                    next_state = S_TRAP;
                end
            end
            S_WB: begin
                reg_write     = 1'b1;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                wb_sel        = (cls == CLS_LOAD) ? WB_MEM :
                                (cls == CLS_JAL || cls == CLS_JALR) ? WB_PC4 : WB_ALU;
                pc_src        = (cls == CLS_JAL) ? PC_JAL : (cls == CLS_JALR) ? PC_JALR : PC_PLUS4;
                next_state    = S_FETCH;
            end
            default: next_state = S_TRAP;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed self-checking bench for multicycle_ctrl_fsm.
module tb_multicycle_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
    logic       instr_retired, illegal_op, mem_timeout;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] state;
    logic [15:0] outs;
    int n_assert = 0;
    int n_fail = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .TW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .instr_retired(instr_retired),
        .illegal_op   (illegal_op),
        .mem_timeout  (mem_timeout),
        .state        (state)
    );

    always #5 clk = ~clk;

    assign outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write,
                   wb_sel, instr_retired, illegal_op, mem_timeout, state};

    // Expected output vector: req we asel irw pcw pcs rw wbs ret ill to state
    function automatic logic [15:0] mk(input logic req, input logic we, input logic as,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic rw, input logic [1:0] wbs, input logic ret,
                                       input logic ill, input logic to, input logic [2:0] st);
        return {req, we, as, irw, pcw, pcs, rw, wbs, ret, ill, to, st};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        n_assert++;
        assert (outs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %04h expected %04h", tag, outs, exp);
        end
    endtask

    // Drive inputs for one cycle, check outputs, then advance past the edge.
    task automatic step(input string tag, input logic rdy, input logic bt, input logic [15:0] exp);
        mem_ready = rdy;
        branch_taken = bt;
        #1;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset_async", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_after_reset", 16'h0000);
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] FETCH_WAIT = 16'h8001;
    localparam logic [15:0] FETCH_RDY  = 16'h9001;
    localparam logic [15:0] DECODE     = 16'h0002;
    localparam logic [15:0] EXEC       = 16'h0003;

    initial begin
        rst_n = 1'b0;
        opcode = 7'b0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        #3;
        chk("reset_state", 16'h0000);
        #9;
        rst_n = 1'b1;
        #1;
        chk("idle", 16'h0000);
        @(posedge clk);
        #1;
        chk("fetch_pre", mk(1,0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));

        opcode = 7'b0010011;
        step("addi_fetch", 1, 0, FETCH_RDY);
        step("addi_decode", 0, 0, DECODE);
        step("addi_exec", 0, 0, EXEC);
        step("addi_wb", 0, 0, mk(0,0,0,0,1,2'b00,1,2'b00,1,0,0,3'd5));

        opcode = 7'b0000011;
        step("lw_fetch", 1, 0, FETCH_RDY);
        step("lw_decode", 0, 0, DECODE);
        opcode = 7'b1111111;
        step("lw_exec", 0, 0, EXEC);
        step("lw_mem_w1", 0, 0, mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0,3'd4));
        step("lw_mem_w2", 0, 0, mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0,3'd4));
        step("lw_mem_rdy", 1, 0, mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0,3'd4));
        step("lw_wb", 0, 0, mk(0,0,0,0,1,2'b00,1,2'b01,1,0,0,3'd5));

        opcode = 7'b1100011;
        step("beq_t_fetch", 1, 0, FETCH_RDY);
        step("beq_t_decode", 0, 0, DECODE);
        step("beq_t_exec", 0, 1, mk(0,0,0,0,1,2'b01,0,2'b00,1,0,0,3'd3));
        step("beq_n_fetch", 1, 0, FETCH_RDY);
        step("beq_n_decode", 0, 0, DECODE);
        step("beq_n_exec", 0, 0, mk(0,0,0,0,1,2'b00,0,2'b00,1,0,0,3'd3));

        opcode = 7'b1100111;
        step("jalr_fetch", 1, 0, FETCH_RDY);
        step("jalr_decode", 0, 0, DECODE);
        step("jalr_exec", 0, 0, EXEC);
        step("jalr_wb", 0, 0, mk(0,0,0,0,1,2'b11,1,2'b10,1,0,0,3'd5));

        opcode = 7'b1101111;
        step("jal_fetch", 1, 0, FETCH_RDY);
        step("jal_decode", 0, 0, DECODE);
        step("jal_exec", 0, 0, EXEC);
        step("jal_wb", 0, 0, mk(0,0,0,0,1,2'b10,1,2'b10,1,0,0,3'd5));

        opcode = 7'b0100011;
        step("sw_fetch", 1, 0, FETCH_RDY);
        step("sw_decode", 0, 0, DECODE);
        step("sw_exec", 0, 0, EXEC);
        step("sw_mem", 1, 0, mk(1,1,1,0,1,2'b00,0,2'b00,1,0,0,3'd4));

        opcode = 7'b1111111;
        step("late_w1", 0, 0, FETCH_WAIT);
        step("late_w2", 0, 0, FETCH_WAIT);
        step("late_w3", 0, 0, FETCH_WAIT);
        step("late_rdy4", 1, 0, FETCH_RDY);
        step("ill_decode", 0, 0, DECODE);
        step("ill_trap1", 1, 0, mk(0,0,0,0,0,2'b00,0,2'b00,0,1,0,3'd6));
        step("ill_trap2", 0, 1, mk(0,0,0,0,0,2'b00,0,2'b00,0,1,0,3'd6));
        step("ill_trap3", 1, 0, mk(0,0,0,0,0,2'b00,0,2'b00,0,1,0,3'd6));

        reset_pulse();
        step("to_w1", 0, 0, FETCH_WAIT);
        step("to_w2", 0, 0, FETCH_WAIT);
        step("to_w3", 0, 0, FETCH_WAIT);
        step("to_w4", 0, 0, FETCH_WAIT);
        step("to_trap1", 1, 0, mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,3'd6));
        step("to_trap2", 0, 0, mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,3'd6));

        reset_pulse();
        opcode = 7'b0000011;
        step("lw2_fetch", 1, 0, FETCH_RDY);
        step("lw2_decode", 0, 0, DECODE);
        step("lw2_exec", 0, 0, EXEC);
        mem_ready = 1'b0;
        #1;
        chk("lw2_mem", mk(1,0,1,0,0,2'b00,0,2'b00,0,0,0,3'd4));
        rst_n = 1'b0;
        #1;
        chk("mid_mem_reset", 16'h0000);
        @(posedge clk);
        #1;
        chk("held_in_reset", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
